// File: rtl/regbus_cmd_initiator.sv
// Register-bus initiator: turns a command stream into single regbus
// transactions, with a per-transaction timeout. The response comes back on a
// valid-ready stream.
// The request bus is laid out MSB first as {valid, addr, write, wdata, wstrb}.
// The response bus is laid out MSB first as {ready, rdata, error}.
// A packed req_t/rsp_t struct declared in that field order can be passed in
// place of the default vectors.
module regbus_cmd_initiator #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type req_t = logic [AddrWidth+DataWidth+DataWidth/8+1:0],
  parameter type rsp_t = logic [DataWidth+1:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic                   cmd_write_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   rsp_timeout_o,
  output req_t                   reg_req_o,
  input  rsp_t                   reg_rsp_i,
  output logic                   busy_o,
  output logic [31:0]            txn_count_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ReqWidth  = AddrWidth + DataWidth + StrbWidth + 2;
  localparam int unsigned RspWidth  = DataWidth + 2;
  localparam int unsigned CntRaw    = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntWidth  = (CntRaw < 1) ? 1 : CntRaw;
  localparam int unsigned CntLast   = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic                   write_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   wstrb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   error_q;
  logic                   timeout_q;
  logic [CntWidth-1:0]    tmo_cnt_q;
  logic [31:0]            txn_cnt_q;

  logic [ReqWidth-1:0]    req_vec;
  logic [RspWidth-1:0]    rsp_vec;
  logic                   slv_ready;
  logic [DataWidth-1:0]   slv_rdata;
  logic                   slv_error;

  logic                   cmd_accept;
  logic                   req_done;
  logic                   req_expire;
  logic                   rsp_handshake;

  // Write responses carry no data, so read data is forced to zero for writes.
  function automatic logic [DataWidth-1:0] resp_data(input logic          is_write,
                                                     input logic [DataWidth-1:0] d);
    return is_write ? '0 : d;
  endfunction

  assign rsp_vec   = reg_rsp_i;
  assign slv_ready = rsp_vec[RspWidth-1];
  assign slv_rdata = rsp_vec[DataWidth:1];
  assign slv_error = rsp_vec[0];

  // Valid is taken straight from the state register.
  // This keeps the request free of any combinational path from the command inputs.
  assign req_vec   = {state_q == REQ, addr_q, write_q, wdata_q, wstrb_q};
  assign reg_req_o = req_vec;

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_error_o   = error_q;
  assign rsp_timeout_o = timeout_q;
  assign txn_count_o   = txn_cnt_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake decode.
  // A slave ready in the timeout cycle beats the timeout.
  always_comb begin
    state_d       = state_q;
    cmd_accept    = 1'b0;
    req_done      = 1'b0;
    req_expire    = 1'b0;
    rsp_handshake = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cmd_accept = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (slv_ready) begin
          req_done = 1'b1;
          state_d  = RESP;
        end else if ((TimeoutCycles != 0) && (tmo_cnt_q == CntWidth'(CntLast))) begin
          req_expire = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_handshake = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the accepted command; it drives the request for the whole REQ phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_accept) begin
      addr_q  <= cmd_addr_i;
      write_q <= cmd_write_i;
      wdata_q <= cmd_wdata_i;
      wstrb_q <= cmd_wstrb_i;
    end
  end

  // Capture the slave response, or synthesise an error response on timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (req_done) begin
      rdata_q   <= resp_data(write_q, slv_rdata);
      error_q   <= slv_error;
      timeout_q <= 1'b0;
    end else if (req_expire) begin
      rdata_q   <= '0;
      error_q   <= 1'b1;
      timeout_q <= 1'b1;
    end
  end

  // Count cycles spent in REQ.
  // The counter is cleared once the response has been handed off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                tmo_cnt_q <= '0;
    else if (rsp_handshake)     tmo_cnt_q <= '0;
    else if (state_q == REQ)    tmo_cnt_q <= tmo_cnt_q + CntWidth'(1);
  end

  // Completed-transaction counter, wraps naturally at 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            txn_cnt_q <= '0;
    else if (rsp_handshake) txn_cnt_q <= txn_cnt_q + 32'd1;
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == REQ) |=> ((state_q != REQ) || $stable(req_vec)));

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable({rsp_rdata_o, rsp_error_o, rsp_timeout_o})));

  a_req_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(req_vec[ReqWidth-1]));

endmodule

// File: doc/regbus_cmd_initiator.md
Name: regbus_cmd_initiator

Overview:
- Register-bus initiator: converts a command stream (addr/wdata/wstrb/write, valid-ready) into single regbus transactions and returns each response on a valid-ready response stream.
- Counterpart to the regbus memory/peripheral responders.
- Used by test benches and boot/config sequencers to program regbus slaves such as the clock manager and boot ROM.
- Adds a per-transaction timeout so a hung slave cannot stall the sequencer.

Parameters:
- AddrWidth, 48, regbus address width.
- DataWidth, 32, regbus data width; wstrb width = DataWidth/8.
- TimeoutCycles, 1024, max cycles a request is held without rsp.ready; 0 disables the timeout.
- req_t, logic, regbus request struct type (valid, addr, write, wdata, wstrb).
- rsp_t, logic, regbus response struct type (ready, rdata, error).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted.
- cmd_addr_i  in  AddrWidth  target address.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_wdata_i  in  DataWidth  write data.
- cmd_wstrb_i  in  DataWidth/8  byte strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DataWidth  read data (0 for writes).
- rsp_error_o  out  1  slave error or timeout.
- rsp_timeout_o  out  1  response caused by timeout.
- reg_req_o  out  req_t  regbus request.
- reg_rsp_i  in  rsp_t  regbus response.
- busy_o  out  1  state != IDLE.
- txn_count_o  out  32  completed transactions (responses handed off), wraps at 2^32.

Behaviour:
- Reset: state IDLE; cmd_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_error_o=0; rsp_timeout_o=0; reg_req_o all-zero; busy_o=0; txn_count_o=0; timeout counter=0. Reset mid-transaction drops reg_req_o.valid asynchronously; no response is produced.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, register addr/write/wdata/wstrb and go to REQ next cycle.
  - reg_req_o.valid rises one cycle after acceptance (registered output, no comb path from cmd to reg_req).
- REQ:
  - reg_req_o.valid=1; addr/write/wdata/wstrb held stable from the latched copy; cmd_ready_o=0.
  - Timeout counter increments each cycle.
  - If reg_rsp_i.ready in the same cycle: capture rdata (forced 0 when write), error, timeout=0; go to RESP; valid drops next cycle.
  - Else if TimeoutCycles!=0 and counter reaches TimeoutCycles-1: go to RESP with rdata=0, error=1, timeout=1; valid drops.
  - If ready and timeout coincide, ready wins: normal response, timeout=0.
  - Minimum request duration is 1 cycle (ready in first REQ cycle).
- RESP:
  - rsp_valid_o=1 with captured fields, held stable until rsp_ready_i.
  - On handshake: txn_count_o+1, go to IDLE, clear timeout counter.
  - cmd_ready_o=0 throughout RESP.
- Throughput: one transaction outstanding. Back-to-back best case is 3 cycles per command (accept, REQ, RESP with rsp_ready_i=1).
- reg_req_o.valid is never high outside REQ.
- Read responses are ignored and nothing is latched while not in REQ.
- busy_o=1 in REQ and RESP.
- TimeoutCycles=1: timeout fires in first REQ cycle unless ready is already high.
- Counter width is clog2(TimeoutCycles+1), minimum 1 bit.
- Assertions:
  - Latched request fields stable while in REQ.
  - Response fields stable while rsp_valid_o && !rsp_ready_i.
  - No X on reg_req_o.valid after reset.

Test Plan:
- Write then read: cmd write addr 0x1000, wdata 0xCAFEF00D, wstrb 0xF, then read addr 0x1000 with a zero-latency memory responder -> write rsp error=0, rdata=0; read rsp rdata=0xCAFEF00D; txn_count_o=2; reg_req_o.valid high exactly 1 cycle each.
- Slave wait states: responder asserts ready after 5 cycles -> reg_req_o.valid high 6 cycles with fields stable; rsp_valid_o rises the cycle after ready.
- Slave error: responder returns error=1 on read 0x2000 -> rsp_error_o=1, rsp_timeout_o=0, rdata captured.
- Timeout: TimeoutCycles=8, responder never ready -> valid high exactly 8 cycles; rsp error=1, timeout=1, rdata=0; next command proceeds normally.
- Response backpressure: rsp_ready_i low for 10 cycles -> rsp_valid_o and fields stable; cmd_ready_o=0; no new reg_req_o.valid until handshake.
- Reset mid-REQ: assert rst_ni low during a wait-stated request -> reg_req_o.valid=0 and rsp_valid_o=0 immediately; txn_count_o=0; cmd_ready_o=1 after reset release.
